// File: rtl/tl45_fetch_if.sv
// tl45_fetch_if: Wishbone pipelined read bus between the fetch stage and
// instruction memory. Signal names keep the fetch stage's point of view
// (o_* driven by the fetch master, i_* driven by the memory slave).
//   o_wb_cyc   - bus cycle in progress
//   o_wb_stb   - request strobe
//   o_wb_addr  - 30-bit word address
//   i_wb_stall - slave cannot accept the strobe this cycle
//   i_wb_ack   - read data valid
//   i_wb_err   - bus error terminating the cycle
//   i_wb_data  - read data
interface tl45_fetch_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [29:0] o_wb_addr;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_addr,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_addr,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );
endinterface

// File: rtl/tl45_fetch.sv
// tl45_fetch: instruction fetch stage of the tl45 pipeline.
// Owns the program counter, issues single-word Wishbone pipelined reads and
// fills the fetch->decode buffer under the pipeline stall/flush protocol.
// A bubble in the buffer is presented as pc=0, inst=0 (NOP).
// Ports:
//   i_clk, i_reset    - clock; synchronous active-high reset
//   i_pipe_stall      - downstream not consuming, buffer holds
//   i_pipe_flush      - redirect to i_flush_pc (low two bits ignored)
//   i_flush_pc        - redirect target
//   o_buf_pc          - PC of the buffered instruction
//   o_buf_inst        - buffered instruction word
//   o_fetch_err       - sticky bus-error flag, cleared by flush or reset
//   wb                - Wishbone master port (tl45_fetch_if.master)
// Every output is a flop; the combinational block only computes next values.
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_flush_pc,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err,
  tl45_fetch_if.master wb
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    ERR
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_inc;
  logic [31:0] hold_pc, hold_pc_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic [31:0] buf_pc_n, buf_inst_n;
  logic        cyc_n, stb_n, err_n;
  logic [29:0] addr_n;

  assign pc_inc = pc + 32'd4;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      hold_pc      <= '0;
      hold_inst    <= '0;
      o_buf_pc     <= '0;
      o_buf_inst   <= '0;
      o_fetch_err  <= 1'b0;
      wb.o_wb_cyc  <= 1'b0;
      wb.o_wb_stb  <= 1'b0;
      wb.o_wb_addr <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      hold_pc      <= hold_pc_n;
      hold_inst    <= hold_inst_n;
      o_buf_pc     <= buf_pc_n;
      o_buf_inst   <= buf_inst_n;
      o_fetch_err  <= err_n;
      wb.o_wb_cyc  <= cyc_n;
      wb.o_wb_stb  <= stb_n;
      wb.o_wb_addr <= addr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    hold_pc_n   = hold_pc;
    hold_inst_n = hold_inst;
    cyc_n       = wb.o_wb_cyc;
    stb_n       = wb.o_wb_stb;
    addr_n      = wb.o_wb_addr;
    err_n       = o_fetch_err;

    // Default buffer behaviour: hold while stalled, otherwise the consumed
    // entry is replaced by a bubble so it is never presented twice.
    if (i_pipe_stall) begin
      buf_pc_n   = o_buf_pc;
      buf_inst_n = o_buf_inst;
    end else begin
      buf_pc_n   = '0;
      buf_inst_n = '0;
    end

    if (i_pipe_flush) begin
      // Abort everything: in-flight read, same-cycle ack, held word, error.
      state_n     = IDLE;
      pc_n        = i_flush_pc & 32'hFFFF_FFFC;
      hold_pc_n   = '0;
      hold_inst_n = '0;
      buf_pc_n    = '0;
      buf_inst_n  = '0;
      cyc_n       = 1'b0;
      stb_n       = 1'b0;
      err_n       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = REQ;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          addr_n  = pc[31:2];
        end
        REQ: begin
          if (!wb.i_wb_stall) begin
            stb_n   = 1'b0;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (wb.i_wb_err) begin
            cyc_n   = 1'b0;
            err_n   = 1'b1;
            state_n = ERR;
          end else if (wb.i_wb_ack) begin
            pc_n = pc_inc;
            if (!i_pipe_stall) begin
              // Keep cyc high and strobe the next word straight away.
              buf_pc_n   = pc;
              buf_inst_n = wb.i_wb_data;
              stb_n      = 1'b1;
              addr_n     = pc_inc[31:2];
              state_n    = REQ;
            end else begin
              hold_pc_n   = pc;
              hold_inst_n = wb.i_wb_data;
              cyc_n       = 1'b0;
              state_n     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!i_pipe_stall) begin
            buf_pc_n   = hold_pc;
            buf_inst_n = hold_inst;
            cyc_n      = 1'b1;
            stb_n      = 1'b1;
            addr_n     = pc[31:2];
            state_n    = REQ;
          end
        end
        ERR: begin
          state_n = ERR;
        end
        default: begin
          state_n = IDLE;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl45_fetch.sv
// tb_tl45_fetch: directed scenarios for tl45_fetch plus a randomized run
// against a stream-level model (consumed instructions must be consecutive
// words from the last redirect, each carrying the memory's word).
module tb_tl45_fetch;
  logic        clk;
  logic        i_reset;
  logic        i_pipe_stall;
  logic        i_pipe_flush;
  logic [31:0] i_flush_pc;
  logic [31:0] o_buf_pc;
  logic [31:0] o_buf_inst;
  logic        o_fetch_err;
  int          tests;
  int          fails;

  tl45_fetch_if wb();

  tl45_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_pipe_stall(i_pipe_stall),
    .i_pipe_flush(i_pipe_flush),
    .i_flush_pc  (i_flush_pc),
    .o_buf_pc    (o_buf_pc),
    .o_buf_inst  (o_buf_inst),
    .o_fetch_err (o_fetch_err),
    .wb          (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A) | 32'h1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_pipe_stall  = 1'b0;
    i_pipe_flush  = 1'b0;
    i_flush_pc    = '0;
    wb.i_wb_stall = 1'b0;
    wb.i_wb_ack   = 1'b0;
    wb.i_wb_err   = 1'b0;
    wb.i_wb_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1'b1;
    step();
    step();
    tests++; if ({o_buf_pc, o_buf_inst} !== 64'h0) begin fails++; $display("FAIL reset_buf: got %h_%h want 0_0", o_buf_pc, o_buf_inst); end
    tests++; if ({wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr, o_fetch_err} !== 33'h0) begin fails++; $display("FAIL reset_bus: got cyc=%b stb=%b addr=%h err=%b want all 0", wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr, o_fetch_err); end
    i_reset = 1'b0;
  endtask

  task automatic test_first_fetch();
    do_reset();
    tests++; if (wb.o_wb_cyc !== 1'b0) begin fails++; $display("FAIL ff_idle_cyc: got %b want 0", wb.o_wb_cyc); end
    step();
    tests++; if ({wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr} !== {2'b11, 30'h40}) begin fails++; $display("FAIL ff_first_stb: got cyc=%b stb=%b addr=%h want 1 1 40", wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr); end
    step();
    tests++; if ({wb.o_wb_cyc, wb.o_wb_stb, o_buf_inst} !== {2'b10, 32'h0}) begin fails++; $display("FAIL ff_wait: got cyc=%b stb=%b inst=%h want 1 0 0", wb.o_wb_cyc, wb.o_wb_stb, o_buf_inst); end
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h0A00_0001;
    step();
    wb.i_wb_ack = 1'b0;
    tests++; if ({o_buf_pc, o_buf_inst} !== {32'h100, 32'h0A00_0001}) begin fails++; $display("FAIL ff_buf: got %h_%h want 00000100_0a000001", o_buf_pc, o_buf_inst); end
    tests++; if ({wb.o_wb_stb, wb.o_wb_addr} !== {1'b1, 30'h41}) begin fails++; $display("FAIL ff_next_addr: got stb=%b addr=%h want 1 41", wb.o_wb_stb, wb.o_wb_addr); end
    step();
    tests++; if ({o_buf_pc, o_buf_inst} !== 64'h0) begin fails++; $display("FAIL ff_bubble: got %h_%h want 0_0", o_buf_pc, o_buf_inst); end
  endtask

  task automatic test_pipe_stall_hold();
    do_reset();
    step();
    step();
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h1111_0001;
    step();
    wb.i_wb_ack = 1'b0;
    i_pipe_stall = 1'b1;
    step();
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h2222_0003;
    step();
    wb.i_wb_ack = 1'b0; wb.i_wb_data = '0;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({wb.o_wb_cyc, wb.o_wb_stb} !== 2'b00) begin fails++; $display("FAIL hold_cyc[%0d]: got cyc=%b stb=%b want 0 0", i, wb.o_wb_cyc, wb.o_wb_stb); end
      tests++; if ({o_buf_pc, o_buf_inst} !== {32'h100, 32'h1111_0001}) begin fails++; $display("FAIL hold_buf[%0d]: got %h_%h want 00000100_11110001", i, o_buf_pc, o_buf_inst); end
      if (i < 2) step();
    end
    i_pipe_stall = 1'b0;
    step();
    tests++; if ({o_buf_pc, o_buf_inst} !== {32'h104, 32'h2222_0003}) begin fails++; $display("FAIL hold_release_buf: got %h_%h want 00000104_22220003", o_buf_pc, o_buf_inst); end
    tests++; if ({wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr} !== {2'b11, 30'h42}) begin fails++; $display("FAIL hold_release_req: got cyc=%b stb=%b addr=%h want 1 1 42", wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr); end
    wb.i_wb_stall = 1'b1;
    step();
    wb.i_wb_stall = 1'b0;
    tests++; if ({o_buf_pc, o_buf_inst} !== 64'h0) begin fails++; $display("FAIL hold_once: got %h_%h want 0_0", o_buf_pc, o_buf_inst); end
  endtask

  task automatic test_flush_in_wait();
    do_reset();
    step();
    step();
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h1111_0001;
    step();
    wb.i_wb_ack = 1'b0;
    i_pipe_stall = 1'b1;
    step();
    i_pipe_flush = 1'b1; i_flush_pc = 32'h203;
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'hDEAD_0001;
    step();
    i_pipe_flush = 1'b0; wb.i_wb_ack = 1'b0; i_pipe_stall = 1'b0;
    tests++; if ({o_buf_pc, o_buf_inst} !== 64'h0) begin fails++; $display("FAIL flush_buf: got %h_%h want 0_0", o_buf_pc, o_buf_inst); end
    tests++; if ({wb.o_wb_cyc, wb.o_wb_stb} !== 2'b00) begin fails++; $display("FAIL flush_cyc_low: got cyc=%b stb=%b want 0 0", wb.o_wb_cyc, wb.o_wb_stb); end
    step();
    tests++; if ({wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr} !== {2'b11, 30'h80}) begin fails++; $display("FAIL flush_new_req: got cyc=%b stb=%b addr=%h want 1 1 80", wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr); end
    tests++; if ({o_buf_pc, o_buf_inst} !== 64'h0) begin fails++; $display("FAIL flush_no_stale: got %h_%h want 0_0", o_buf_pc, o_buf_inst); end
    step();
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h3333_0005;
    step();
    wb.i_wb_ack = 1'b0;
    tests++; if ({o_buf_pc, o_buf_inst} !== {32'h200, 32'h3333_0005}) begin fails++; $display("FAIL flush_first_inst: got %h_%h want 00000200_33330005", o_buf_pc, o_buf_inst); end
  endtask

  task automatic test_bus_error();
    do_reset();
    step();
    step();
    wb.i_wb_err = 1'b1; wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h5555_0001;
    step();
    wb.i_wb_err = 1'b0; wb.i_wb_ack = 1'b0;
    tests++; if ({o_fetch_err, wb.o_wb_cyc} !== 2'b10) begin fails++; $display("FAIL err_set: got err=%b cyc=%b want 1 0", o_fetch_err, wb.o_wb_cyc); end
    tests++; if ({o_buf_pc, o_buf_inst} !== 64'h0) begin fails++; $display("FAIL err_no_data: got %h_%h want 0_0", o_buf_pc, o_buf_inst); end
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if ({o_fetch_err, wb.o_wb_cyc, wb.o_wb_stb} !== 3'b100) begin fails++; $display("FAIL err_quiet[%0d]: got err=%b cyc=%b stb=%b want 1 0 0", i, o_fetch_err, wb.o_wb_cyc, wb.o_wb_stb); end
    end
    i_pipe_flush = 1'b1; i_flush_pc = 32'h0;
    step();
    i_pipe_flush = 1'b0;
    tests++; if ({o_fetch_err, wb.o_wb_cyc} !== 2'b00) begin fails++; $display("FAIL err_clear: got err=%b cyc=%b want 0 0", o_fetch_err, wb.o_wb_cyc); end
    step();
    tests++; if ({wb.o_wb_stb, wb.o_wb_addr} !== {1'b1, 30'h0}) begin fails++; $display("FAIL err_resume: got stb=%b addr=%h want 1 0", wb.o_wb_stb, wb.o_wb_addr); end
  endtask

  task automatic test_wb_stall();
    int accepts;
    accepts = 0;
    do_reset();
    step();
    for (int i = 0; i < 7; i++) begin
      wb.i_wb_stall = (i < 4);
      if (i < 5) begin
        tests++; if ({wb.o_wb_stb, wb.o_wb_addr} !== {1'b1, 30'h40}) begin fails++; $display("FAIL wbstall_steady[%0d]: got stb=%b addr=%h want 1 40", i, wb.o_wb_stb, wb.o_wb_addr); end
      end
      if (wb.o_wb_stb && !wb.i_wb_stall) accepts++;
      step();
    end
    wb.i_wb_stall = 1'b0;
    tests++; if (accepts !== 1) begin fails++; $display("FAIL wbstall_accepts: got %0d want 1", accepts); end
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h6666_0009;
    step();
    wb.i_wb_ack = 1'b0;
    tests++; if ({o_buf_pc, o_buf_inst} !== {32'h100, 32'h6666_0009}) begin fails++; $display("FAIL wbstall_buf: got %h_%h want 00000100_66660009", o_buf_pc, o_buf_inst); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    i_pipe_flush = 1'b1; i_flush_pc = 32'hFFFF_FFFC;
    step();
    i_pipe_flush = 1'b0;
    step();
    tests++; if ({wb.o_wb_stb, wb.o_wb_addr} !== {1'b1, 30'h3FFF_FFFF}) begin fails++; $display("FAIL wrap_req: got stb=%b addr=%h want 1 3fffffff", wb.o_wb_stb, wb.o_wb_addr); end
    step();
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h4444_0007;
    step();
    wb.i_wb_ack = 1'b0;
    tests++; if ({o_buf_pc, o_buf_inst} !== {32'hFFFF_FFFC, 32'h4444_0007}) begin fails++; $display("FAIL wrap_buf: got %h_%h want fffffffc_44440007", o_buf_pc, o_buf_inst); end
    tests++; if ({wb.o_wb_stb, wb.o_wb_addr} !== {1'b1, 30'h0}) begin fails++; $display("FAIL wrap_next: got stb=%b addr=%h want 1 0", wb.o_wb_stb, wb.o_wb_addr); end
    i_pipe_stall = 1'b1;
    step();
    i_reset = 1'b1; wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h7777_0001;
    step();
    i_reset = 1'b0; wb.i_wb_ack = 1'b0; i_pipe_stall = 1'b0;
    tests++; if ({wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr, o_fetch_err} !== 33'h0) begin fails++; $display("FAIL midwait_reset_bus: got cyc=%b stb=%b addr=%h err=%b want all 0", wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_addr, o_fetch_err); end
    tests++; if ({o_buf_pc, o_buf_inst} !== 64'h0) begin fails++; $display("FAIL midwait_reset_buf: got %h_%h want 0_0", o_buf_pc, o_buf_inst); end
  endtask

  task automatic test_random();
    logic        pending, model_err, prev_hold, prev_stb_stall, prev_flush;
    logic        acc, do_ack, do_err;
    int          delay, consumed;
    logic [29:0] pend_addr, prev_addr;
    logic [31:0] exp_req_pc, exp_next_pc, tgt, prev_pc, prev_inst;
    do_reset();
    pending = 0; model_err = 0; prev_hold = 0; prev_stb_stall = 0; prev_flush = 0;
    delay = 0; consumed = 0; pend_addr = '0; prev_addr = '0;
    exp_req_pc = 32'h100; exp_next_pc = 32'h100; prev_pc = '0; prev_inst = '0;
    for (int c = 0; c < 3000; c++) begin
      tests++; if (o_fetch_err !== model_err) begin fails++; $display("FAIL rnd_err[%0d]: got %b want %b", c, o_fetch_err, model_err); end
      if (model_err) begin
        tests++; if ({wb.o_wb_cyc, wb.o_wb_stb} !== 2'b00) begin fails++; $display("FAIL rnd_err_quiet[%0d]: got cyc=%b stb=%b want 0 0", c, wb.o_wb_cyc, wb.o_wb_stb); end
      end
      if (prev_hold) begin
        tests++; if ({o_buf_pc, o_buf_inst} !== {prev_pc, prev_inst}) begin fails++; $display("FAIL rnd_hold[%0d]: got %h_%h want %h_%h", c, o_buf_pc, o_buf_inst, prev_pc, prev_inst); end
      end
      if (prev_stb_stall) begin
        tests++; if ({wb.o_wb_stb, wb.o_wb_addr} !== {1'b1, prev_addr}) begin fails++; $display("FAIL rnd_stb_steady[%0d]: got stb=%b addr=%h want 1 %h", c, wb.o_wb_stb, wb.o_wb_addr, prev_addr); end
      end
      if (prev_flush) begin
        tests++; if ({wb.o_wb_cyc, o_buf_pc, o_buf_inst} !== 65'h0) begin fails++; $display("FAIL rnd_flush[%0d]: got cyc=%b buf=%h_%h want 0 0_0", c, wb.o_wb_cyc, o_buf_pc, o_buf_inst); end
      end
      if (pending) begin
        tests++; if ({wb.o_wb_cyc, wb.o_wb_stb} !== 2'b10) begin fails++; $display("FAIL rnd_outstanding[%0d]: got cyc=%b stb=%b want 1 0", c, wb.o_wb_cyc, wb.o_wb_stb); end
      end

      i_pipe_flush = ($urandom_range(0, 39) == 0) || (model_err && $urandom_range(0, 3) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 2) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      i_flush_pc   = tgt;
      i_pipe_stall = ($urandom_range(0, 2) == 0);
      wb.i_wb_stall = 1'b0; wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0; wb.i_wb_data = $urandom;
      acc = 0; do_ack = 0; do_err = 0;

      if (i_pipe_flush) begin
        // A stray same-cycle ack must be discarded by the flush.
        wb.i_wb_ack = pending;
      end else begin
        if (wb.o_wb_stb) begin
          wb.i_wb_stall = ($urandom_range(0, 2) == 0);
          if (!wb.i_wb_stall) begin
            acc = 1;
            tests++; if (wb.o_wb_addr !== exp_req_pc[31:2]) begin fails++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, wb.o_wb_addr, exp_req_pc[31:2]); end
          end
        end else if (pending) begin
          if (delay == 0) begin
            if ($urandom_range(0, 39) == 0) begin
              do_err = 1; wb.i_wb_err = 1'b1; wb.i_wb_ack = 1'($urandom_range(0, 1));
            end else begin
              do_ack = 1; wb.i_wb_ack = 1'b1; wb.i_wb_data = mem_word({pend_addr, 2'b00});
            end
          end else begin
            delay--;
          end
        end
        if (!i_pipe_stall) begin
          if (o_buf_inst !== 32'h0) begin
            tests++; if ({o_buf_pc, o_buf_inst} !== {exp_next_pc, mem_word(exp_next_pc)}) begin fails++; $display("FAIL rnd_stream[%0d]: got %h_%h want %h_%h", c, o_buf_pc, o_buf_inst, exp_next_pc, mem_word(exp_next_pc)); end
            exp_next_pc = exp_next_pc + 32'd4;
            consumed++;
          end else begin
            tests++; if (o_buf_pc !== 32'h0) begin fails++; $display("FAIL rnd_bubble_pc[%0d]: got %h want 0", c, o_buf_pc); end
          end
        end
      end

      if (i_pipe_flush) begin
        pending = 0; model_err = 0;
        exp_req_pc = tgt & 32'hFFFF_FFFC;
        exp_next_pc = exp_req_pc;
      end else begin
        if (acc) begin pending = 1; pend_addr = wb.o_wb_addr; delay = $urandom_range(0, 2); end
        if (do_err) begin pending = 0; model_err = 1; end
        else if (do_ack) begin pending = 0; exp_req_pc = exp_req_pc + 32'd4; end
      end
      prev_hold      = i_pipe_stall && !i_pipe_flush;
      prev_pc        = o_buf_pc;
      prev_inst      = o_buf_inst;
      prev_stb_stall = !i_pipe_flush && wb.o_wb_stb && wb.i_wb_stall;
      prev_addr      = wb.o_wb_addr;
      prev_flush     = i_pipe_flush;
      step();
    end
    clear_inputs();
    tests++; if (consumed < 100) begin fails++; $display("FAIL rnd_progress: got %0d instructions want >= 100", consumed); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    i_reset = 1'b1;
    clear_inputs();
    test_reset();
    test_first_fetch();
    test_pipe_stall_hold();
    test_flush_in_wait();
    test_bus_error();
    test_wb_stall();
    test_wrap_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tl45_fetch.md
# tl45_fetch

Instruction fetch stage for the tl45 pipeline. Owns the program counter and issues single-word Wishbone pipelined reads to instruction memory. Drives the fetch→decode buffer (`o_buf_pc`, `o_buf_inst`) under the same stall/flush protocol the decode stage obeys. Emits all-zero words (NOP) whenever no fetched instruction is ready.

## Interface
- `RESET_PC`, 32'h0000_0000, byte address of the first fetch after reset.
- `i_clk`  in  1  clock; all state updates on posedge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_pipe_stall`  in  1  downstream not consuming; output buffer must hold.
- `i_pipe_flush`  in  1  redirect request; discards buffer and in-flight fetch.
- `i_flush_pc`  in  32  new PC, sampled when `i_pipe_flush`=1; bits [1:0] ignored, forced to 0.
- `o_buf_pc`  out  32  PC of instruction in buffer; 0 for a bubble.
- `o_buf_inst`  out  32  instruction word; 0 (NOP) for a bubble.
- `o_wb_cyc`, `o_wb_stb`  out  1  Wishbone cycle/strobe, registered.
- `o_wb_addr`  out  30  word address, equals `pc[31:2]`, registered.
- `i_wb_stall`  in  1  slave cannot accept strobe this cycle.
- `i_wb_ack`  in  1  read data valid.
- `i_wb_err`  in  1  bus error terminating the cycle.
- `i_wb_data`  in  32  read data.
- `o_fetch_err`  out  1  sticky bus-error flag.

## Operation
- Internal state: `pc` (32 b), `hold_inst`/`hold_pc` (32 b each), FSM. States: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: cyc=0, stb=0. Always goes to REQ next cycle.
- REQ: cyc=1, stb=1, addr=`pc[31:2]`. If `!i_wb_stall`, stb←0 and go WAIT; else stay.
- WAIT: cyc=1, stb=0. Ack and errors are honoured only here.
  - On `i_wb_ack` with `!i_pipe_stall`: buffer ← {pc, `i_wb_data`}, `pc` ← pc+4 (mod 2^32), go REQ.
  - On `i_wb_ack` with `i_pipe_stall`: hold ← {pc, `i_wb_data`}, `pc` ← pc+4, cyc←0, go HOLD.
  - On `i_wb_err`: cyc←0, `o_fetch_err`←1, go ERR. `pc` unchanged.
  - If both ack and err are asserted, err wins.
- HOLD: cyc=0. When `!i_pipe_stall`, buffer ← hold and go REQ.
- ERR: cyc=0 and no further requests. Leave ERR only on flush or reset.
- Buffer rule, applied every cycle not covered above:
  - `i_pipe_stall`=1: buffer holds.
  - `i_pipe_stall`=0: buffer ← {0, 0} (bubble).
  - The same instruction is never presented on two consumed cycles.
- Flush (priority over everything except reset):
  - buffer ← {0, 0} regardless of stall.
  - `pc` ← {`i_flush_pc[31:2]`, 2'b00}.
  - cyc/stb ← 0 (aborts any in-flight read); `o_fetch_err` ← 0; go IDLE.
  - Same-cycle ack is discarded, and so is any held word.
- Reset: `pc`←RESET_PC. Buffer, hold, cyc, stb, addr, `o_fetch_err` all ←0. Go IDLE. Any in-flight cycle is dropped.
- `o_wb_addr` updates only on entry to REQ. Its reset value is 0.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Reset release: IDLE at cycle 0, first stb at cycle 1, addr=`RESET_PC[31:2]`.
- Zero-wait memory (ack the cycle after stb is accepted), no stalls:
  - REQ, WAIT, REQ, WAIT…
  - One instruction every 2 cycles.
  - Each instruction appears in the buffer the cycle after its ack. Bubbles appear between instructions.
- Flush → IDLE (cyc low for exactly 1 cycle) → REQ at the new PC. First new instruction reaches the buffer no earlier than 3 cycles after the flush edge.
- Each added cycle of `i_wb_stall` in REQ, or of ack delay in WAIT, adds one cycle of latency.
- At most one outstanding read.
- PC wrap: 32'hFFFF_FFFC + 4 = 0.

## Test plan
- Reset, RESET_PC=0x100, memory returns 0x0A00_0001 at word 0x40 with zero wait → stb at cycle 1, addr 0x40; buffer {0x100, 0x0A000001} one cycle after ack; next addr 0x41; bubbles on intervening cycles.
- `i_pipe_stall` held high from ack for 3 cycles → FSM in HOLD, cyc=0, buffer unchanged. On release, buffer = held {pc, inst} exactly once, then REQ at pc+4.
- Flush with `i_flush_pc`=0x203 during WAIT, ack arriving the same cycle → ack data discarded, buffer zero, cyc low one cycle, next addr 0x80.
- `i_wb_err` in WAIT → `o_fetch_err`=1, no further stb, buffer bubbles. Then flush to 0x0 → error cleared and fetch resumes at addr 0.
- `i_wb_stall` high 4 cycles in REQ → stb and addr held steady; exactly one request is accepted.
- PC at 0xFFFF_FFFC fetched → next addr 0x0. Reset asserted mid-WAIT → cyc=0 next cycle and all outputs zero.
